// File: rtl/shift_reg_ser_driver_pkg.sv
// Shared types and default parameters for the serial shift-register driver.
package ser_driver_pkg;

  // Gray-coded so every legal transition flips exactly one state bit; the
  // sclk and latch decodes therefore cannot glitch.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHIFT_LO = 2'b01,
    SHIFT_HI = 2'b11,
    LATCH    = 2'b10
  } ser_state_t;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam bit          DEF_MSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_reg_ser_driver_if.sv
// Load handshake and serial pins of the driver; SER_READBACK_EN adds the
// serial-in readback signals.
interface shift_reg_ser_driver_if
  import ser_driver_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             load_valid;
  logic [WIDTH-1:0] data_in;
  logic             load_ready;
  logic             sclk;
  logic             sdata;
  logic             latch;
  logic             busy;
`ifdef SER_READBACK_EN
  logic             sin;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
`endif

  modport master (
    output load_valid, data_in,
    input  load_ready, sclk, sdata, latch, busy
`ifdef SER_READBACK_EN
    , output sin,
    input  rdata, rdata_valid
`endif
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, sclk, sdata, latch, busy
`ifdef SER_READBACK_EN
    , input sin,
    output rdata, rdata_valid
`endif
  );

endinterface

// File: rtl/shift_reg_ser_driver_clk_div_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV cycles, restarted by clear.
module clk_div_tick
  import ser_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (cnt == CNT_W'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_ser_driver.sv
// Parallel-to-serial driver for external shift/storage registers.
// Optional `SER_READBACK_EN collects a serial return stream into rdata.
module shift_reg_ser_driver
  import ser_driver_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
  input logic                   clk,
  input logic                   rst,
  shift_reg_ser_driver_if.slave bus
);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  ser_state_t       state, state_nxt;
  logic             tick;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sr, shift_nxt;
  logic             fill;
  logic             accept, shift_done, last_bit;

  clk_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign accept     = bus.load_valid && (state == IDLE);
  assign shift_done = (state == SHIFT_HI) && tick;
  assign last_bit   = (bit_cnt == BIT_W'(WIDTH - 1));

`ifdef SER_READBACK_EN
  assign fill = bus.sin;
`else
  assign fill = 1'b0;
`endif

  assign shift_nxt = MSB_FIRST ? {sr[WIDTH-2:0], fill} : {fill, sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bus.load_valid) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick)           state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick)           state_nxt = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (tick)           state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.sclk       = (state == SHIFT_HI);
    bus.latch      = (state == LATCH);
    bus.sdata      = 1'b0;
    if (state == SHIFT_LO || state == SHIFT_HI) begin
      bus.sdata = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end
  end

`ifdef SER_READBACK_EN
  logic [WIDTH-1:0] rdata_q;
  logic             rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
`endif

  // The register only moves on the sclk falling edge, so sdata is stable
  // through every rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
`ifdef SER_READBACK_EN
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
`endif
    end else begin
`ifdef SER_READBACK_EN
      rdata_valid_q <= 1'b0;
`endif
      if (accept) begin
        sr      <= bus.data_in;
        bit_cnt <= '0;
      end else if (shift_done) begin
        sr      <= shift_nxt;
        bit_cnt <= bit_cnt + 1'b1;
`ifdef SER_READBACK_EN
        if (last_bit) begin
          rdata_q       <= shift_nxt;
          rdata_valid_q <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_ser_driver.sv
// Directed bench: u0 is WIDTH=8/CLK_DIV=1/LSB-first, u1 is WIDTH=8/CLK_DIV=4/MSB-first.
// Readback checks are built only when SER_READBACK_EN is defined.
module tb_shift_reg_ser_driver;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shift_reg_ser_driver_if #(.WIDTH(8)) i0 ();
  shift_reg_ser_driver_if #(.WIDTH(8)) i1 ();

  shift_reg_ser_driver #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u0 (
    .clk (clk), .rst (rst), .bus (i0.slave));
  shift_reg_ser_driver #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) u1 (
    .clk (clk), .rst (rst), .bus (i1.slave));

`ifdef SER_READBACK_EN
  logic [7:0] ext = 8'h00;
  logic       sd_cap = 1'b0;
  int         rv_cnt = 0;
  assign i0.sin = ext[0];
  assign i1.sin = 1'b0;
  always @(posedge i0.sclk) sd_cap = i0.sdata;
  always @(negedge i0.sclk) ext <= {sd_cap, ext[7:1]};
  always @(negedge clk) if (i0.rdata_valid === 1'b1) rv_cnt++;
`endif

  // Per-DUT observation of sclk edges, level run lengths and strobe cycles.
  logic [63:0] seq[2];
  int edges[2], latch_cyc[2], busy_cyc[2], hi_cyc[2], lo_cyc[2], bad_runs[2], run[2];
  logic prev_sclk[2];

  task automatic clr(input int k);
    seq[k] = '0; edges[k] = 0; latch_cyc[k] = 0; busy_cyc[k] = 0;
    hi_cyc[k] = 0; lo_cyc[k] = 0; bad_runs[k] = 0; run[k] = 0; prev_sclk[k] = 1'b0;
  endtask

  task automatic mon(input int k, input logic sc, input logic sd, input logic la,
                     input logic bs, input int div);
    if (sc && !prev_sclk[k]) begin
      seq[k] = {seq[k][62:0], sd};
      edges[k]++;
    end
    if (sc) begin
      hi_cyc[k]++;
      run[k]++;
    end else begin
      if (prev_sclk[k] && run[k] != div) bad_runs[k]++;
      run[k] = 0;
    end
    if (la) latch_cyc[k]++;
    if (bs) busy_cyc[k]++;
    if (bs && !sc && !la) lo_cyc[k]++;
    prev_sclk[k] = sc;
  endtask

  always @(negedge clk) begin
    mon(0, i0.sclk, i0.sdata, i0.latch, i0.busy, 1);
    mon(1, i1.sclk, i1.sdata, i1.latch, i1.busy, 4);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int k);
    return (k != 0) ? i1.busy : i0.busy;
  endfunction

  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int g = 0; g < 1000 && busy_of(k) === 1'b1; g++) begin
      n++;
      step();
    end
  endtask

  task automatic wait_busy(input int k, output int idle);
    idle = 0;
    while (busy_of(k) !== 1'b1 && idle < 1000) begin
      idle++;
      step();
    end
  endtask

  int n;
  int idle;

  initial begin
    rst = 1'b0;
    i0.load_valid = 1'b0; i0.data_in = 8'h00;
    i1.load_valid = 1'b0; i1.data_in = 8'h00;
    clr(0); clr(1);
    step();
    check("rst_ready0", i0.load_ready, 1);
    check("rst_busy0",  i0.busy,       0);
    check("rst_sclk0",  i0.sclk,       0);
    check("rst_latch0", i0.latch,      0);
    check("rst_sdata0", i0.sdata,      0);
    check("rst_ready1", i1.load_ready, 1);
    check("rst_sclk1",  i1.sclk,       0);
    step();
    rst = 1'b1;
    step();

    // LSB-first, CLK_DIV=1, 8'hA5
    i0.load_valid = 1'b1; i0.data_in = 8'hA5; clr(0);
    step();
    i0.load_valid = 1'b0;
    count_busy(0, n);
    check("a5_frame_len", n, 17);
    check("a5_bits",      seq[0][7:0], 8'b1010_0101);
    check("a5_edges",     edges[0], 8);
    check("a5_latch_cyc", latch_cyc[0], 1);
    check("a5_idle_sdata", i0.sdata, 0);
    check("a5_idle_sclk",  i0.sclk,  0);

    // MSB-first, CLK_DIV=4, 8'h81
    i1.load_valid = 1'b1; i1.data_in = 8'h81; clr(1);
    step();
    i1.load_valid = 1'b0;
    count_busy(1, n);
    check("81_frame_len", n, 68);
    check("81_bits",      seq[1][7:0], 8'b1000_0001);
    check("81_edges",     edges[1], 8);
    check("81_latch_cyc", latch_cyc[1], 4);
    check("81_hi_cyc",    hi_cyc[1], 32);
    check("81_lo_cyc",    lo_cyc[1], 32);
    check("81_bad_runs",  bad_runs[1], 0);

    // Offer 8'hFF while 8'h00 is shifting
    i0.load_valid = 1'b1; i0.data_in = 8'h00; clr(0);
    step();
    i0.data_in = 8'hFF;
    n = 0;
    for (int g = 0; g < 1000 && i0.busy === 1'b1; g++) begin
      n++;
      if (n == 3) check("busy_ready_low", i0.load_ready, 0);
      if (n == 10) i0.load_valid = 1'b0;
      step();
    end
    check("busy_frame_len", n, 17);
    check("busy_bits",      seq[0][7:0], 8'h00);
    check("busy_edges",     edges[0], 8);
    repeat (3) step();
    check("busy_no_late_accept", i0.busy, 0);

    // Back-to-back frames with load_valid held high
    i0.data_in = 8'h0F; i0.load_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_busy(0, idle);
      check("b2b_idle_gap", idle, 1);
      if (f == 2) i0.load_valid = 1'b0;
      i0.data_in = (i0.data_in == 8'h0F) ? 8'hF0 : 8'h0F;
      clr(0);
      count_busy(0, n);
      check("b2b_frame_len", n, 17);
      check("b2b_bits", seq[0][7:0], (f % 2 == 0) ? 8'hF0 : 8'h0F);
    end
    step(); step();
    check("b2b_stop", i0.busy, 0);

    // Reset during bit 3 of a frame
    i1.load_valid = 1'b1; i1.data_in = 8'hFF; clr(1);
    step();
    i1.load_valid = 1'b0;
    for (int g = 0; g < 1000 && edges[1] < 4; g++) step();
    check("abort_pre_sclk",  i1.sclk,  1);
    check("abort_pre_sdata", i1.sdata, 1);
    rst = 1'b0;
    #1;
    check("abort_sclk",  i1.sclk,       0);
    check("abort_sdata", i1.sdata,      0);
    check("abort_latch", i1.latch,      0);
    check("abort_busy",  i1.busy,       0);
    check("abort_ready", i1.load_ready, 1);
    clr(1);
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();
    check("abort_no_latch",  latch_cyc[1], 0);
    check("abort_no_resume", busy_cyc[1],  0);

    // Accept on the first edge after reset release
    rst = 1'b0;
    step();
    rst = 1'b1; i1.load_valid = 1'b1; i1.data_in = 8'h81; clr(1);
    step();
    check("first_accept", i1.busy, 1);
    i1.load_valid = 1'b0;
    count_busy(1, n);
    check("first_frame_len", n, 68);
    check("first_bits", seq[1][7:0], 8'h81);

`ifdef SER_READBACK_EN
    // Loop sdata back through an external 8-bit register preloaded with 8'h3C
    ext = 8'h3C; rv_cnt = 0;
    i0.load_valid = 1'b1; i0.data_in = 8'h5A; clr(0);
    step();
    i0.load_valid = 1'b0;
    count_busy(0, n);
    step();
    check("rb_rdata",    i0.rdata, 8'h3C);
    check("rb_valid_n",  rv_cnt, 1);
    check("rb_ext_data", ext, 8'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_ser_driver.md
SHIFT_REG_SER_DRIVER -- requirements
Module: shift_reg_ser_driver

Interface
REQ-001 Parameter WIDTH, default 16: bits per frame, legal range 2..64.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per sclk half-period, legal range 1..255.
REQ-003 Parameter MSB_FIRST, default 0: 0 shifts data_in[0] first, 1 shifts data_in[WIDTH-1] first.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low.
REQ-006 load_valid  input  1  a frame is offered on data_in.
REQ-007 data_in  input  WIDTH  parallel frame to serialise.
REQ-008 load_ready  output  1  block accepts a frame this cycle.
REQ-009 sclk  output  1  serial shift clock to external shift registers.
REQ-010 sdata  output  1  serial data; stable across every sclk rising edge.
REQ-011 latch  output  1  storage-register strobe, high after the last bit.
REQ-012 busy  output  1  frame in progress (inverse of load_ready).

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-014 In IDLE: load_ready=1, sclk=0, latch=0, sdata=0; a frame is accepted when load_valid && load_ready.
REQ-015 On accept, the block SHALL capture data_in into an internal shift register, clear the bit counter, and enter SHIFT_LO on the next edge.
REQ-016 SHIFT_LO SHALL hold sclk=0 for exactly CLK_DIV cycles with sdata driving the current bit, then enter SHIFT_HI.
REQ-017 SHIFT_HI SHALL hold sclk=1 for exactly CLK_DIV cycles, keeping sdata unchanged; on exit the register SHALL shift one position toward the output end, zero-filling.
REQ-018 After SHIFT_HI of bit WIDTH-1, the block SHALL enter LATCH instead of SHIFT_LO.
REQ-019 LATCH SHALL hold latch=1, sclk=0 for exactly CLK_DIV cycles, then return to IDLE.
REQ-020 Frame length SHALL be exactly (2*WIDTH+1)*CLK_DIV cycles from the first SHIFT_LO cycle to the first IDLE cycle.
REQ-021 load_valid while busy SHALL be ignored; data_in changes mid-frame SHALL not affect the frame.
REQ-022 load_valid held high continuously SHALL start a new frame in the first IDLE cycle, giving one IDLE cycle between frames.
REQ-023 Divider counter width SHALL be $clog2(CLK_DIV+1); bit counter width SHALL be $clog2(WIDTH+1); neither SHALL wrap within a frame.

Reset
REQ-024 While rst=0, the block SHALL force state=IDLE, counters=0, shift register=0, sclk=0, latch=0, sdata=0, load_ready=1, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no latch pulse; the frame SHALL not resume after release.
REQ-026 The first accept SHALL be possible in the first clk edge after rst deasserts.

Configuration
REQ-027 Macro SER_READBACK_EN, when defined, SHALL add input sin (1 bit), output rdata (WIDTH), and output rdata_valid (1 bit).
REQ-028 With SER_READBACK_EN, sin SHALL be sampled on the last clk cycle of each SHIFT_HI into the vacated end of the shift register.
REQ-029 With SER_READBACK_EN, rdata SHALL be updated to the collected WIDTH bits (first-sampled bit at the position that was shifted out first) and rdata_valid SHALL pulse for one cycle on entry to LATCH; reset SHALL clear both.
REQ-030 Without SER_READBACK_EN, those ports SHALL not exist and the shift register SHALL zero-fill.

Structure
REQ-031 Package ser_driver_pkg SHALL hold the FSM state enum (ser_state_t) and default parameter constants.
REQ-032 The sclk half-period divider SHALL be a sub-module clk_div_tick, producing a one-cycle tick every CLK_DIV cycles, restartable by a clear input.

Verification
REQ-033 WIDTH=8, CLK_DIV=1, MSB_FIRST=0: load 8'hA5 -> sdata at 8 sclk rising edges = 1,0,1,0,0,1,0,1; latch high 1 cycle; IDLE 17 cycles after first SHIFT_LO.
REQ-034 WIDTH=8, CLK_DIV=4, MSB_FIRST=1: load 8'h81 -> edges 1,0,0,0,0,0,0,1; each sclk level lasts 4 cycles; latch high 4 cycles; frame 68 cycles.
REQ-035 Offer 8'hFF while busy with 8'h00 -> 8'hFF is not accepted, load_ready=0, and all 8 bits of the current frame are 0.
REQ-036 Drop rst to 0 after bit 3 of a frame -> sclk, latch and sdata go to 0 immediately with no latch pulse; after release, load_ready=1.
REQ-037 load_valid held high with data alternating 8'h0F/8'hF0 -> back-to-back frames, each separated by exactly 1 IDLE cycle.
REQ-038 With SER_READBACK_EN, loop sdata to sin through an external 8-bit register preloaded with 8'h3C -> rdata=8'h3C and rdata_valid pulses once.
